// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates requests at the memory stage, strobes CP0, flushes and redirects fetch.
// Optional branch-delay EPC correction is enabled by defining EXC_CTRL_BD_EN.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_F000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid_i,
    input  logic [31:0]      mem_pc_i,
    input  logic             irq_i,
    input  logic             ri_i,
    input  logic             ov_i,
    input  logic             sys_i,
    input  logic             bp_i,
    input  logic             eret_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             mem_in_ds_i,
    output logic             kill_o,
    output logic             exception_o,
    output logic [31:0]      epc_o,
    output logic [4:0]       cause_type_o,
    output logic             bd_o,
    output logic             eret_o,
    output logic             flush_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] exc_cnt_o
);

    typedef enum logic [1:0] {IDLE, CAPTURE, REDIRECT, ERET_RD} state_t;

    state_t             state_q;
    logic               exception_q, eret_q, flush_q, redirect_q, bd_q;
    logic [31:0]        epc_q, redirect_pc_q;
    logic [4:0]         cause_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               any_exc;
    logic [4:0]         code_d;
    logic [31:0]        epc_d;
    logic               bd_d;
    logic [CNT_W-1:0]   cnt_d;

    assign any_exc = irq_i | ri_i | ov_i | sys_i | bp_i;

    always_comb begin
        code_d = 5'd0;
        if (irq_i)      code_d = 5'd0;
        else if (ri_i)  code_d = 5'd10;
        else if (ov_i)  code_d = 5'd12;
        else if (sys_i) code_d = 5'd8;
        else if (bp_i)  code_d = 5'd9;
    end

`ifdef EXC_CTRL_BD_EN
    // A delay-slot instruction restarts at its branch so the branch is re-evaluated.
    assign bd_d  = mem_in_ds_i;
    assign epc_d = mem_in_ds_i ? (mem_pc_i - 32'd4) : mem_pc_i;
`else
    logic unused_ds;
    assign unused_ds = mem_in_ds_i;
    assign bd_d      = 1'b0;
    assign epc_d     = mem_pc_i;
`endif

    assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign kill_o = !rst && (state_q == IDLE) && mem_valid_i && (any_exc || eret_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            exception_q   <= 1'b0;
            eret_q        <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            bd_q          <= 1'b0;
            epc_q         <= '0;
            redirect_pc_q <= '0;
            cause_q       <= '0;
            cnt_q         <= '0;
        end else begin
            exception_q <= 1'b0;
            eret_q      <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_valid_i && any_exc) begin
                        state_q     <= CAPTURE;
                        exception_q <= 1'b1;
                        flush_q     <= 1'b1;
                        cause_q     <= code_d;
                        epc_q       <= epc_d;
                        bd_q        <= bd_d;
                    end else if (mem_valid_i && eret_i) begin
                        state_q       <= ERET_RD;
                        eret_q        <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= cp0_epc_i;
                    end
                end
                CAPTURE: begin
                    state_q       <= REDIRECT;
                    flush_q       <= 1'b1;
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= EXC_VECTOR;
                    cnt_q         <= cnt_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign exception_o   = exception_q;
    assign eret_o        = eret_q;
    assign flush_o       = flush_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign epc_o         = epc_q;
    assign cause_type_o  = cause_q;
    assign bd_o          = bd_q;
    assign busy_o        = (state_q != IDLE);
    assign exc_cnt_o     = cnt_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomised bench for exc_ctrl against a cycle-schedule reference model.
module tb_exc_ctrl;
    localparam logic [31:0] VEC = 32'h0000_F000;
    localparam int          CW  = 3;
    localparam int          N   = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_valid_i = 1'b0, irq_i = 1'b0, ri_i = 1'b0, ov_i = 1'b0;
    logic          sys_i = 1'b0, bp_i = 1'b0, eret_i = 1'b0, mem_in_ds_i = 1'b0;
    logic [31:0]   mem_pc_i = '0, cp0_epc_i = '0;
    logic          kill_o, exception_o, bd_o, eret_o, flush_o, redirect_o, busy_o;
    logic [31:0]   epc_o, redirect_pc_o;
    logic [4:0]    cause_type_o;
    logic [CW-1:0] exc_cnt_o;

    exc_ctrl #(.EXC_VECTOR(VEC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
        .irq_i(irq_i), .ri_i(ri_i), .ov_i(ov_i), .sys_i(sys_i), .bp_i(bp_i),
        .eret_i(eret_i), .cp0_epc_i(cp0_epc_i), .mem_in_ds_i(mem_in_ds_i),
        .kill_o(kill_o), .exception_o(exception_o), .epc_o(epc_o),
        .cause_type_o(cause_type_o), .bd_o(bd_o), .eret_o(eret_o),
        .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .busy_o(busy_o), .exc_cnt_o(exc_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-cycle schedule of expected strobes plus latched values.
    bit          e_exc[N], e_eret[N], e_flush[N], e_redir[N], e_busy[N];
    int          t = 0, free_at = 0, rpc_at = -1, cnt_at = -1;
    logic [31:0] m_epc = '0, m_rpc = '0;
    logic [4:0]  m_cause = '0;
    logic        m_bd = 1'b0;
    int          m_cnt = 0;
    int          n_exc_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, t, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [31:0] pc,
                        input bit irq, input bit ri, input bit ov, input bit sy,
                        input bit bp, input bit er, input logic [31:0] cepc, input bit ds);
        bit ekill, any;
        @(negedge clk);
        t++;
        rst = r; mem_valid_i = v; mem_pc_i = pc; irq_i = irq; ri_i = ri; ov_i = ov;
        sys_i = sy; bp_i = bp; eret_i = er; cp0_epc_i = cepc; mem_in_ds_i = ds;
        #1;
        if (t == rpc_at) m_rpc = VEC;
        if (t == cnt_at) m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                e_exc[t+k] = 0; e_eret[t+k] = 0; e_flush[t+k] = 0;
                e_redir[t+k] = 0; e_busy[t+k] = 0;
            end
            free_at = 0; rpc_at = -1; cnt_at = -1;
            m_epc = '0; m_rpc = '0; m_cause = '0; m_bd = 1'b0; m_cnt = 0;
        end
        any   = irq | ri | ov | sy | bp;
        ekill = !r && (t >= free_at) && v && (any || er);
        chk("kill",      32'(kill_o),        32'(ekill));
        chk("exception", 32'(exception_o),   32'(e_exc[t]));
        chk("eret",      32'(eret_o),        32'(e_eret[t]));
        chk("flush",     32'(flush_o),       32'(e_flush[t]));
        chk("redirect",  32'(redirect_o),    32'(e_redir[t]));
        chk("busy",      32'(busy_o),        32'(e_busy[t]));
        chk("epc",       epc_o,              m_epc);
        chk("cause",     32'(cause_type_o),  32'(m_cause));
        chk("bd",        32'(bd_o),          32'(m_bd));
        chk("rpc",       redirect_pc_o,      m_rpc);
        chk("cnt",       32'(exc_cnt_o),     32'(m_cnt));
        if (exception_o === 1'b1) n_exc_pulses++;
        if (ekill && any) begin
            m_cause = irq ? 5'd0 : ri ? 5'd10 : ov ? 5'd12 : sy ? 5'd8 : 5'd9;
`ifdef EXC_CTRL_BD_EN
            m_bd  = ds;
            m_epc = ds ? pc - 32'd4 : pc;
`else
            m_bd  = 1'b0;
            m_epc = pc;
`endif
            e_exc[t+1] = 1; e_flush[t+1] = 1; e_busy[t+1] = 1;
            e_flush[t+2] = 1; e_redir[t+2] = 1; e_busy[t+2] = 1;
            rpc_at = t + 2; cnt_at = t + 2; free_at = t + 3;
        end else if (ekill) begin
            m_rpc = cepc;
            e_eret[t+1] = 1; e_flush[t+1] = 1; e_redir[t+1] = 1; e_busy[t+1] = 1;
            free_at = t + 2;
        end
    endtask

    task automatic idle_step();
        step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic sys_at(input logic [31:0] pc);
        step(0, 1, pc, 0, 0, 0, 1, 0, 0, 32'h0, 0);
    endtask

    initial begin
        int pulses_before;
        step(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        step(1, 1, 32'h40, 1, 0, 0, 1, 0, 0, 32'h0, 0);
        idle_step();

        // Syscall at 0x400
        sys_at(32'h0000_0400);
        repeat (3) idle_step();
        chk("sys_cnt", 32'(exc_cnt_o), 32'd1);

        // Priority: irq beats ov/sys with a single capture pulse, then ov beats bp
        pulses_before = n_exc_pulses;
        step(0, 1, 32'h500, 1, 0, 1, 1, 0, 0, 32'h0, 0);
        repeat (3) idle_step();
        chk("prio_pulses", 32'(n_exc_pulses - pulses_before), 32'd1);
        step(0, 1, 32'h504, 0, 0, 1, 0, 1, 0, 32'h0, 0);
        repeat (3) idle_step();
        chk("prio_ov", 32'(cause_type_o), 32'd12);

        // ERET
        step(0, 1, 32'h600, 0, 0, 0, 0, 0, 1, 32'h0000_0804, 0);
        repeat (2) idle_step();

        // Busy masking: bp held through the sequence is taken at T+3
        sys_at(32'h700);
        repeat (3) step(0, 1, 32'h704, 0, 0, 0, 0, 1, 0, 32'h0, 0);
        repeat (3) idle_step();

        // Interrupt without a valid instruction is held off
        repeat (5) step(0, 0, 32'h100, 1, 0, 0, 0, 0, 0, 32'h0, 0);
        step(0, 1, 32'h100, 1, 0, 0, 0, 0, 0, 32'h0, 0);
        repeat (3) idle_step();

        // Delay-slot instruction, including wrap-around at PC 0
        step(0, 1, 32'h204, 0, 1, 0, 0, 0, 0, 32'h0, 1);
        repeat (3) idle_step();
        step(0, 1, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0, 1);
        repeat (3) idle_step();

        // Reset during CAPTURE
        sys_at(32'h800);
        step(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        repeat (3) idle_step();

        // Counter saturation
        repeat (9) begin
            sys_at(32'h900);
            repeat (2) idle_step();
        end
        chk("cnt_sat", 32'(exc_cnt_o), 32'((1 << CW) - 1));

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                 $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                 $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0));
        end
        repeat (4) idle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
